// File: rtl/mtimer_pkg.sv
// Shared machine-timer constants: register word offsets, mtimecmp reset value
// and the byte-lane merge used by every writable word.
package mtimer_pkg;

  // Word index carried on addr
  typedef enum logic [1:0] {
    MTIMER__MTIME_LO    = 2'd0,
    MTIMER__MTIME_HI    = 2'd1,
    MTIMER__MTIMECMP_LO = 2'd2,
    MTIMER__MTIMECMP_HI = 2'd3
  } mtimer_reg_e;

  // mtimecmp comes out of reset at its maximum so no interrupt fires until
  // software programs a real deadline.
  localparam logic [63:0] MTIMER__MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] mtimer_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = be[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mtimer.sv
// Machine timer: 64-bit mtime advanced every PRESCALE clocks, 64-bit mtimecmp,
// registered level interrupt while mtime >= mtimecmp, and a simple word bus.
//
// Bus handshake: an access is accepted in every cycle where sel && (rd || wr);
// there is no back-pressure. ack pulses for exactly one cycle in the cycle
// after acceptance, with rdata carrying the addressed word as it stood in the
// acceptance cycle (before any write or tick of that cycle). rdata is 0 in
// every cycle where ack is 0, and on acks of write-only accesses.
module mtimer
  import mtimer_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        timer
);

  localparam int unsigned PW = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic          timer_q, timer_d;

  mtimer_reg_e   reg_sel;
  logic          accept;
  logic          wr_en;
  logic          tick;
  logic          mtime_wr;
  logic [31:0]   rd_word;

  // Bus decode and prescaler: tick fires in the cycle the prescaler wraps.
  always_comb begin
    reg_sel = mtimer_reg_e'(addr);
    accept  = sel && (rd || wr);
    wr_en   = sel && wr;
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // mtime: a write that touches any byte replaces the increment for that cycle.
  always_comb begin
    mtime_d  = mtime_q;
    mtime_wr = wr_en && (be != 4'b0000) &&
               ((reg_sel == MTIMER__MTIME_LO) || (reg_sel == MTIMER__MTIME_HI));
    if (mtime_wr) begin
      if (reg_sel == MTIMER__MTIME_HI) begin
        mtime_d[63:32] = mtimer_merge(mtime_q[63:32], wdata, be);
      end else begin
        mtime_d[31:0]  = mtimer_merge(mtime_q[31:0], wdata, be);
      end
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  // mtimecmp: byte-enabled writes only.
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (wr_en && (reg_sel == MTIMER__MTIMECMP_LO)) begin
      mtimecmp_d[31:0]  = mtimer_merge(mtimecmp_q[31:0], wdata, be);
    end else if (wr_en && (reg_sel == MTIMER__MTIMECMP_HI)) begin
      mtimecmp_d[63:32] = mtimer_merge(mtimecmp_q[63:32], wdata, be);
    end
  end

  // Read mux, ack and compare, all from the current (pre-update) state.
  always_comb begin
    rd_word = '0;
    case (reg_sel)
      MTIMER__MTIME_LO:    rd_word = mtime_q[31:0];
      MTIMER__MTIME_HI:    rd_word = mtime_q[63:32];
      MTIMER__MTIMECMP_LO: rd_word = mtimecmp_q[31:0];
      MTIMER__MTIMECMP_HI: rd_word = mtimecmp_q[63:32];
      default:             rd_word = '0;
    endcase
    rdata_d = (accept && rd) ? rd_word : '0;
    ack_d   = accept;
    timer_d = (mtime_q >= mtimecmp_q);
  end

  // State registers; reset also drops any ack still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= MTIMER__MTIMECMP_RST;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      timer_q    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      timer_q    <= timer_d;
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign timer = timer_q;

endmodule

// File: tb/tb_mtimer.sv
// Bench for mtimer: two instances (PRESCALE=1 and PRESCALE=4) share one bus and
// are checked every cycle against a cycle-count based reference model.
module tb_mtimer;
  import mtimer_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        sel, rd, wr;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata1, rdata4;
  logic        ack1, ack4, timer1, timer4;

  always #5 clk = ~clk;

  mtimer #(.PRESCALE(1)) u_dut1 (
    .clk(clk), .rst(rst), .sel(sel), .addr(addr), .rd(rd), .wr(wr),
    .wdata(wdata), .be(be), .rdata(rdata1), .ack(ack1), .timer(timer1)
  );

  mtimer #(.PRESCALE(4)) u_dut4 (
    .clk(clk), .rst(rst), .sel(sel), .addr(addr), .rd(rd), .wr(wr),
    .wdata(wdata), .be(be), .rdata(rdata4), .ack(ack4), .timer(timer4)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Index 0 models the PRESCALE=1 instance, index 1 the PRESCALE=4 instance.
  logic [63:0] m_mtime [2];
  logic [63:0] m_cmp   [2];
  logic        m_timer [2];
  logic        m_ack;
  int unsigned m_cyc;
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q4[$];

  function automatic logic [63:0] write_half(input logic [63:0] v, input logic hi,
                                             input logic [31:0] wd, input logic [3:0] b);
    logic [31:0] mask, old_w, new_w;
    mask  = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    old_w = hi ? v[63:32] : v[31:0];
    new_w = (old_w & ~mask) | (wd & mask);
    return hi ? {new_w, v[31:0]} : {v[63:32], new_w};
  endfunction

  function automatic logic [31:0] pick_word(input logic [63:0] t, input logic [63:0] c,
                                            input logic [1:0] a);
    logic [63:0] src;
    src = a[1] ? c : t;
    return a[0] ? src[63:32] : src[31:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mtime[i] = 64'd0;
      m_cmp[i]   = 64'hFFFF_FFFF_FFFF_FFFF;
      m_timer[i] = 1'b0;
    end
    m_ack = 1'b0;
    m_cyc = 0;
    exp_q1.delete();
    exp_q4.delete();
  endtask

  // Advance the model by one non-reset clock edge using the current bus inputs.
  task automatic model_edge();
    logic        acc, tick;
    int unsigned p;
    logic [63:0] t, c;
    logic [31:0] w;
    acc = sel && (rd || wr);
    for (int i = 0; i < 2; i++) begin
      p    = (i == 0) ? 1 : 4;
      tick = ((m_cyc % p) == (p - 1));
      t    = m_mtime[i];
      c    = m_cmp[i];
      w    = pick_word(t, c, addr);
      m_timer[i] = (t >= c);
      if (acc && wr && !addr[1] && (be != 4'b0000)) m_mtime[i] = write_half(t, addr[0], wdata, be);
      else if (tick)                                 m_mtime[i] = t + 64'd1;
      if (acc && wr && addr[1]) m_cmp[i] = write_half(c, addr[0], wdata, be);
      if (acc) begin
        if (i == 0) exp_q1.push_back(rd ? w : 32'h0);
        else        exp_q4.push_back(rd ? w : 32'h0);
      end
    end
    m_ack = acc;
    m_cyc++;
  endtask

  task automatic compare_outputs();
    check_eq("ack1", ack1, m_ack);
    check_eq("ack4", ack4, m_ack);
    if (m_ack && exp_q1.size() > 0 && exp_q4.size() > 0) begin
      check_eq("rdata1", rdata1, exp_q1.pop_front());
      check_eq("rdata4", rdata4, exp_q4.pop_front());
    end else begin
      check_eq("rdata1_idle", rdata1, 32'h0);
      check_eq("rdata4_idle", rdata4, 32'h0);
    end
    check_eq("timer1", timer1, m_timer[0]);
    check_eq("timer4", timer4, m_timer[1]);
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; drives one bus cycle and checks the result.
  task automatic step(input logic s, input logic r, input logic w, input logic [1:0] a,
                      input logic [31:0] d, input logic [3:0] b);
    sel = s; rd = r; wr = w; addr = a; wdata = d; be = b;
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    step(1'b1, 1'b0, 1'b1, a, d, b);
  endtask

  task automatic bus_rd(input logic [1:0] a);
    step(1'b1, 1'b1, 1'b0, a, 32'h0, 4'h0);
  endtask

  // Asserts reset leaving the bus as it was, so any pending request is dropped.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_ack1", ack1, 1'b0);
    check_eq("rst_ack4", ack4, 1'b0);
    check_eq("rst_rdata1", rdata1, 32'h0);
    check_eq("rst_timer1", timer1, 1'b0);
    check_eq("rst_timer4", timer4, 1'b0);
    @(posedge clk);
    @(posedge clk);
    sel = 1'b0; rd = 1'b0; wr = 1'b0; addr = 2'd0; wdata = 32'h0; be = 4'h0;
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic prev;
    logic found;
    rst = 1'b1;
    sel = 1'b0; rd = 1'b0; wr = 1'b0; addr = 2'd0; wdata = 32'h0; be = 4'h0;
    do_reset();

    // Idle count after reset; read returns the pre-read value.
    idle(10);
    bus_rd(MTIMER__MTIME_LO);
    check_eq("idle_lo1", rdata1, 32'd10);
    check_eq("idle_lo4", rdata4, 32'd2);
    check_eq("idle_timer1", timer1, 1'b0);
    bus_rd(MTIMER__MTIMECMP_HI);
    check_eq("cmp_hi_rst", rdata1, 32'hFFFF_FFFF);

    // Deadline 20 on the PRESCALE=4 instance.
    do_reset();
    bus_wr(MTIMER__MTIMECMP_HI, 32'h0, 4'hF);
    bus_wr(MTIMER__MTIMECMP_LO, 32'd20, 4'hF);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      prev = timer4;
      idle(1);
      if (timer4 && !prev) found = 1'b1;
    end
    check_eq("cmp20_seen", found, 1'b1);
    bus_rd(MTIMER__MTIME_LO);
    check_eq("cmp20_mtime", rdata4, 32'd20);
    idle(3);

    // Wrap from all-ones with mtimecmp at reset value.
    do_reset();
    bus_wr(MTIMER__MTIME_LO, 32'hFFFF_FFFF, 4'hF);
    bus_wr(MTIMER__MTIME_HI, 32'hFFFF_FFFF, 4'hF);
    idle(1);
    check_eq("wrap_pulse", timer1, 1'b1);
    idle(1);
    check_eq("wrap_drop", timer1, 1'b0);
    bus_rd(MTIMER__MTIME_HI);
    check_eq("wrap_hi", rdata1, 32'h0);
    idle(2);

    // Partial byte write coincident with a tick on both instances.
    do_reset();
    bus_wr(MTIMER__MTIME_LO, 32'h1122_3344, 4'hF);
    bus_wr(MTIMER__MTIME_HI, 32'h0, 4'hF);
    idle(1);
    bus_wr(MTIMER__MTIME_LO, 32'h0000_AB00, 4'b0010);
    bus_rd(MTIMER__MTIME_LO);
    check_eq("be_tick1", rdata1, 32'h1122_AB45);
    check_eq("be_tick4", rdata4, 32'h1122_AB44);
    bus_wr(MTIMER__MTIME_LO, 32'h5555_5555, 4'h0);
    idle(2);

    // Simultaneous read and write returns the old word.
    do_reset();
    step(1'b1, 1'b1, 1'b1, MTIMER__MTIMECMP_LO, 32'd5, 4'hF);
    check_eq("rw_ack", ack1, 1'b1);
    check_eq("rw_old", rdata1, 32'hFFFF_FFFF);
    bus_rd(MTIMER__MTIMECMP_LO);
    check_eq("rw_new", rdata1, 32'd5);

    // Reset while an ack is pending.
    bus_rd(MTIMER__MTIME_LO);
    do_reset();
    idle(1);
    check_eq("abort_ack", ack1, 1'b0);
    bus_rd(MTIMER__MTIMECMP_LO);
    check_eq("abort_cmp_lo", rdata1, 32'hFFFF_FFFF);

    // Randomized traffic with small values so the compare toggles.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 64)),
             4'($urandom_range(0, 15)));
      end
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus never completes.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion expected end of stimulus");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/mtimer.md
MTIMER -- requirements
Module: mtimer

Interface
REQ-001 SHALL have parameter PRESCALE, default 1, clk cycles per mtime increment; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  core clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port sel  input  1  peripheral select; the access is qualified by sel.
REQ-005 SHALL have port addr  input  2  word index: 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI.
REQ-006 SHALL have port rd  input  1  read request.
REQ-007 SHALL have port wr  input  1  write request.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port be  input  4  byte enables for wdata; bit i enables byte i.
REQ-010 SHALL have port rdata  output  32  read data, valid only while ack=1, else 0.
REQ-011 SHALL have port ack  output  1  one-cycle access completion pulse.
REQ-012 SHALL have port timer  output  1  machine timer interrupt level to the core's interrupt controller.

Function
REQ-013 SHALL hold a 64-bit mtime, a 64-bit mtimecmp and a prescaler counter of width clog2(PRESCALE)+1.
REQ-014 Prescaler SHALL count 0..PRESCALE-1; in the cycle it equals PRESCALE-1 it SHALL return to 0 and mtime SHALL increment by 1 (tick).
REQ-015 PRESCALE=1 SHALL tick every cycle.
REQ-016 mtime SHALL wrap from 0xFFFF_FFFF_FFFF_FFFF to 0 with no side effect.
REQ-017 An access SHALL be accepted in any cycle with sel && (rd || wr); no back-pressure, no outstanding limit.
REQ-018 ack SHALL be 1 exactly in the cycle after acceptance, for one cycle; back-to-back accesses SHALL give back-to-back acks.
REQ-019 Read data SHALL be the addressed word as held in the acceptance cycle (pre-write, pre-tick value).
REQ-020 Writes SHALL update only bytes with be set; be=0 SHALL still ack and change nothing.
REQ-021 Write to an mtime word in a tick cycle: written bytes take wdata, the whole 64-bit mtime SHALL NOT increment that cycle; prescaler unaffected.
REQ-022 rd && wr together SHALL perform the write and return the pre-write value.
REQ-023 Unsigned compare: timer SHALL be registered, timer(n+1) = (mtime(n) >= mtimecmp(n)); one-cycle latency from any register change.
REQ-024 timer SHALL stay asserted until software raises mtimecmp above mtime or writes mtime below mtimecmp; no sticky pending state in this block.
REQ-025 Accesses with sel=0 SHALL be ignored entirely.

Reset
REQ-026 On rst: mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, prescaler=0, timer=0, ack=0, rdata=0.
REQ-027 Reset mid-access SHALL abort it: no ack pulse after rst deasserts for requests preceding reset.
REQ-028 First tick after reset release SHALL occur PRESCALE cycles after the first non-reset edge.

Structure
REQ-029 Register word offsets and mtimecmp reset value SHALL be shared constants in the common header set with the ISA/CSR definitions (MTIMER__ prefix).
REQ-030 Single module; no sub-module; compare and bus decode inline.

Verification
REQ-031 Reset, PRESCALE=1, idle 10 cycles -> read MTIME_LO returns 9 or 10 consistent with REQ-019, timer=0.
REQ-032 PRESCALE=4, write MTIMECMP_HI=0 then MTIMECMP_LO=20 -> timer rises exactly one cycle after mtime reaches 20.
REQ-033 Write MTIME_LO=0xFFFF_FFFF, MTIME_HI=0xFFFF_FFFF, PRESCALE=1 -> next tick mtime=0; with mtimecmp=0xFFFF_FFFF_FFFF_FFFF, timer pulses one cycle and drops.
REQ-034 Write MTIME_LO with be=0b0010, wdata=0x0000_AB00 coincident with a tick -> byte1=0xAB, other bytes unchanged, no increment.
REQ-035 rd && wr to MTIMECMP_LO with wdata=5 -> ack next cycle, rdata=0xFFFF_FFFF, then read returns 5.
REQ-036 Assert rst while ack pending -> ack=0, all registers at REQ-026 values.
